// File: rtl/fir_sample_feeder_pkg.sv
// Shared definitions for the FIR sample feeder: FSM encoding, AXI response
// codes and the filter peripheral's register map.
package fir_sample_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RESP,
      ST_AR,
      ST_R,
      ST_OUT
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // Filter register map (byte addresses on the 6-bit AXI4-Lite bus).
   localparam logic [5:0] FILTER_ADDR = 6'h00;
   localparam logic [5:0] SAMPLE_ADDR = 6'h04;
   localparam logic [5:0] MARKER_ADDR = 6'h0C;

endpackage

// File: rtl/fir_sample_feeder_if.sv
// AXI4-Lite bus between the sample feeder (master) and the FIR filter
// peripheral (slave).
interface fir_sample_feeder_if #(
   parameter int AW = 6,
   parameter int DW = 32
);

   logic [AW-1:0] AWADDR;
   logic          AWVALID;
   logic          AWREADY;
   logic [DW-1:0] WDATA;
   logic [3:0]    WSTRB;
   logic          WVALID;
   logic          WREADY;
   logic [1:0]    BRESP;
   logic          BVALID;
   logic          BREADY;
   logic [AW-1:0] ARADDR;
   logic          ARVALID;
   logic          ARREADY;
   logic [DW-1:0] RDATA;
   logic [1:0]    RRESP;
   logic          RVALID;
   logic          RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/fir_sample_feeder.sv
// Pushes each stream sample into the FIR filter's sample register over
// AXI4-Lite, polls the same register until result-valid, then streams the result out.
module fir_sample_feeder #(
   parameter int C_M_AXI_ADDR_WIDTH = 6,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] SAMPLE_ADDR =
      C_M_AXI_ADDR_WIDTH'(fir_sample_feeder_pkg::SAMPLE_ADDR),
   parameter int MAX_POLLS = 255
) (
   input  logic                 M_AXI_ACLK,
   input  logic                 M_AXI_ARESET,
   input  logic [15:0]          s_sample_tdata,
   input  logic                 s_sample_tvalid,
   output logic                 s_sample_tready,
   output logic [15:0]          m_result_tdata,
   output logic                 m_result_tvalid,
   input  logic                 m_result_tready,
   fir_sample_feeder_if.master  m_axi,
   output logic                 err_resp,
   output logic                 err_timeout,
   output logic [15:0]          sample_count
);

   import fir_sample_feeder_pkg::*;

   localparam logic [7:0] POLL_LAST = 8'(MAX_POLLS - 1);

   state_t                          state_q, state_d;
   logic                            awvalid_q, awvalid_d;
   logic                            wvalid_q, wvalid_d;
   logic                            bready_q, bready_d;
   logic                            arvalid_q, arvalid_d;
   logic                            rready_q, rready_d;
   logic                            tready_q, tready_d;
   logic                            tvalid_q, tvalid_d;
   logic [15:0]                     tdata_q, tdata_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [7:0]                      poll_q, poll_d;
   logic                            err_resp_q, err_resp_d;
   logic                            err_timeout_q, err_timeout_d;
   logic [15:0]                     count_q, count_d;

   // Only the result-valid flag and the 16-bit result are meaningful in RDATA.
   logic unused_rdata;
   assign unused_rdata = ^m_axi.RDATA[C_M_AXI_DATA_WIDTH-2:16];

   always_comb begin
      state_d       = state_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      tready_d      = tready_q;
      tvalid_d      = tvalid_q;
      tdata_d       = tdata_q;
      wdata_d       = wdata_q;
      poll_d        = poll_q;
      err_resp_d    = err_resp_q;
      err_timeout_d = err_timeout_q;
      count_d       = count_q;

      case (state_q)
         ST_IDLE: begin
            tready_d = 1'b1;
            if (s_sample_tvalid && tready_q) begin
               wdata_d   = {{(C_M_AXI_DATA_WIDTH-16){s_sample_tdata[15]}}, s_sample_tdata};
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               tready_d  = 1'b0;
               state_d   = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // Address and data channels complete independently, in any order.
            if (m_axi.AWREADY) awvalid_d = 1'b0;
            if (m_axi.WREADY)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (m_axi.BVALID) begin
               if (m_axi.BRESP != AXI_RESP_OKAY) err_resp_d = 1'b1;
               bready_d  = 1'b0;
               poll_d    = 8'd0;
               arvalid_d = 1'b1;
               state_d   = ST_AR;
            end
         end
         ST_AR: begin
            if (m_axi.ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_R;
            end
         end
         ST_R: begin
            if (m_axi.RVALID) begin
               rready_d = 1'b0;
               if (m_axi.RRESP != AXI_RESP_OKAY) begin
                  err_resp_d = 1'b1;
                  tready_d   = 1'b1;
                  state_d    = ST_IDLE;
               end else if (m_axi.RDATA[C_M_AXI_DATA_WIDTH-1]) begin
                  tdata_d  = m_axi.RDATA[15:0];
                  tvalid_d = 1'b1;
                  state_d  = ST_OUT;
               end else if (poll_q == POLL_LAST) begin
                  err_timeout_d = 1'b1;
                  tready_d      = 1'b1;
                  state_d       = ST_IDLE;
               end else begin
                  poll_d    = poll_q + 8'd1;
                  arvalid_d = 1'b1;
                  state_d   = ST_AR;
               end
            end
         end
         ST_OUT: begin
            if (m_result_tready) begin
               tvalid_d = 1'b0;
               count_d  = count_q + 16'd1;
               tready_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            tvalid_d  = 1'b0;
            tready_d  = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_q       <= ST_IDLE;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         tready_q      <= 1'b0;
         tvalid_q      <= 1'b0;
         tdata_q       <= 16'd0;
         wdata_q       <= '0;
         poll_q        <= 8'd0;
         err_resp_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         count_q       <= 16'd0;
      end else begin
         state_q       <= state_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         tready_q      <= tready_d;
         tvalid_q      <= tvalid_d;
         tdata_q       <= tdata_d;
         wdata_q       <= wdata_d;
         poll_q        <= poll_d;
         err_resp_q    <= err_resp_d;
         err_timeout_q <= err_timeout_d;
         count_q       <= count_d;
      end
   end

   assign m_axi.AWADDR  = SAMPLE_ADDR;
   assign m_axi.AWVALID = awvalid_q;
   assign m_axi.WDATA   = wdata_q;
   assign m_axi.WSTRB   = 4'hF;
   assign m_axi.WVALID  = wvalid_q;
   assign m_axi.BREADY  = bready_q;
   assign m_axi.ARADDR  = SAMPLE_ADDR;
   assign m_axi.ARVALID = arvalid_q;
   assign m_axi.RREADY  = rready_q;

   assign s_sample_tready = tready_q;
   assign m_result_tdata  = tdata_q;
   assign m_result_tvalid = tvalid_q;
   assign err_resp        = err_resp_q;
   assign err_timeout     = err_timeout_q;
   assign sample_count    = count_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: an AXI4-Lite slave model with
// configurable ready delays, response codes and poll count before result-valid.
module tb_fir_sample_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_tdata = 16'd0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [15:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        err_resp;
   logic        err_timeout;
   logic [15:0] sample_count;

   int checks = 0;
   int failures = 0;

   fir_sample_feeder_if #(.AW(6), .DW(32)) axi ();

   fir_sample_feeder #(
      .C_M_AXI_ADDR_WIDTH (6),
      .C_M_AXI_DATA_WIDTH (32),
      .SAMPLE_ADDR        (6'h04),
      .MAX_POLLS          (8)
   ) dut (
      .M_AXI_ACLK      (clk),
      .M_AXI_ARESET    (rst),
      .s_sample_tdata  (s_tdata),
      .s_sample_tvalid (s_tvalid),
      .s_sample_tready (s_tready),
      .m_result_tdata  (m_tdata),
      .m_result_tvalid (m_tvalid),
      .m_result_tready (m_tready),
      .m_axi           (axi),
      .err_resp        (err_resp),
      .err_timeout     (err_timeout),
      .sample_count    (sample_count)
   );

   always #5 clk = ~clk;

   // Slave model configuration
   int          aw_delay = 0;
   int          w_delay = 0;
   int          zero_reads = 0;
   logic [1:0]  bresp_cfg = 2'b00;
   logic [31:0] result_word = 32'h0;

   // Slave model state and observations
   int          aw_cnt, w_cnt, r_served;
   bit          aw_done, w_done, b_fire, r_pending, r_fire;
   int          aw_hs, w_hs, b_hs, ar_hs, r_hs, res_hs;
   logic [31:0] last_wdata;
   logic [5:0]  last_awaddr, last_araddr;
   logic [3:0]  last_wstrb;
   bit          w_low_aw_high, bready_early, tvalid_seen;

   initial begin
      axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
      axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = 32'h0; axi.RRESP = 2'b00;
   end

   // Slave inputs change on the falling edge; a handshake decided here
   // completes on the following rising edge.
   always @(negedge clk) begin
      if (rst) begin
         axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0;
         axi.ARREADY = 1'b0; axi.RVALID = 1'b0;
         aw_cnt = 0; w_cnt = 0; aw_done = 0; w_done = 0;
         b_fire = 0; r_pending = 0; r_fire = 0;
      end else begin
         if (b_fire) begin axi.BVALID = 1'b0; b_fire = 0; end
         if (aw_done && w_done && !axi.BVALID) begin
            axi.BVALID = 1'b1; axi.BRESP = bresp_cfg; aw_done = 0; w_done = 0;
         end
         if (axi.BVALID && axi.BREADY) begin b_fire = 1; b_hs++; end

         if (axi.AWVALID) begin
            if (aw_cnt >= aw_delay) begin
               axi.AWREADY = 1'b1; aw_hs++; aw_done = 1; aw_cnt = 0;
               last_awaddr = axi.AWADDR;
            end else begin
               axi.AWREADY = 1'b0; aw_cnt++;
            end
         end else begin
            axi.AWREADY = 1'b0; aw_cnt = 0;
         end

         if (axi.WVALID) begin
            if (w_cnt >= w_delay) begin
               axi.WREADY = 1'b1; w_hs++; w_done = 1; w_cnt = 0;
               last_wdata = axi.WDATA; last_wstrb = axi.WSTRB;
            end else begin
               axi.WREADY = 1'b0; w_cnt++;
            end
         end else begin
            axi.WREADY = 1'b0; w_cnt = 0;
         end

         if (axi.AWVALID && !axi.WVALID) w_low_aw_high = 1;
         if (axi.BREADY && (axi.AWVALID || axi.WVALID)) bready_early = 1;

         if (r_fire) begin axi.RVALID = 1'b0; r_fire = 0; end
         if (r_pending && !axi.RVALID) begin
            axi.RVALID = 1'b1;
            axi.RRESP  = 2'b00;
            axi.RDATA  = (r_served >= zero_reads) ? result_word : 32'h0;
            r_served++;
            r_pending = 0;
         end
         if (axi.RVALID && axi.RREADY) begin r_fire = 1; r_hs++; end

         if (axi.ARVALID) begin
            axi.ARREADY = 1'b1; ar_hs++; r_pending = 1; last_araddr = axi.ARADDR;
         end else begin
            axi.ARREADY = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (m_tvalid && m_tready) res_hs++;
         if (m_tvalid) tvalid_seen = 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: sim_time actual=%0t required<400000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_counts();
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; res_hs = 0; r_served = 0;
      w_low_aw_high = 0; bready_early = 0; tvalid_seen = 0;
      last_wdata = 32'h0; last_awaddr = 6'h0; last_araddr = 6'h0; last_wstrb = 4'h0;
   endtask

   task automatic send_sample(input logic [15:0] s);
      int n = 0;
      @(negedge clk);
      s_tdata = s; s_tvalid = 1'b1;
      while (!s_tready && n < 100) begin @(negedge clk); n++; end
      if (!s_tready) begin
         checks++; failures++;
         $display("FAIL send_sample: s_sample_tready actual=0 required=1 within 100 cycles");
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
   endtask

   task automatic wait_result(input int bound);
      int n = 0;
      @(negedge clk);
      while (!m_tvalid && n < bound) begin @(negedge clk); n++; end
      if (!m_tvalid) begin
         checks++; failures++;
         $display("FAIL wait_result: m_result_tvalid actual=0 required=1 within %0d cycles", bound);
      end
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      @(negedge clk);
      while (!s_tready && n < bound) begin @(negedge clk); n++; end
      if (!s_tready) begin
         checks++; failures++;
         $display("FAIL wait_idle: s_sample_tready actual=0 required=1 within %0d cycles", bound);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, m_tvalid, s_tready} !== 7'b0) begin
         failures++;
         $display("FAIL reset_handshakes: actual=%b required=0000000",
                  {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, m_tvalid, s_tready});
      end
      checks++;
      if ({err_resp, err_timeout} !== 2'b00) begin
         failures++; $display("FAIL reset_errors: actual=%b required=00", {err_resp, err_timeout});
      end
      checks++;
      if (sample_count !== 16'd0 || m_tdata !== 16'd0) begin
         failures++;
         $display("FAIL reset_data: count=%h tdata=%h required 0000/0000", sample_count, m_tdata);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (s_tready !== 1'b1) begin
         failures++; $display("FAIL reset_idle_ready: actual=%b required=1", s_tready);
      end
   endtask

   task automatic test_basic();
      aw_delay = 0; w_delay = 0; bresp_cfg = 2'b00;
      zero_reads = 3; result_word = 32'h8000_1234;
      clear_counts();
      send_sample(16'h8001);
      wait_result(300);
      checks++;
      if (m_tdata !== 16'h1234) begin
         failures++; $display("FAIL basic_tdata: actual=%h required=1234", m_tdata);
      end
      wait_idle(50);
      checks++;
      if (last_wdata !== 32'hFFFF_8001) begin
         failures++; $display("FAIL basic_wdata: actual=%h required=ffff8001", last_wdata);
      end
      checks++;
      if (last_awaddr !== 6'h04 || last_araddr !== 6'h04 || last_wstrb !== 4'hF) begin
         failures++;
         $display("FAIL basic_addr_strb: aw=%h ar=%h strb=%h required 04/04/f",
                  last_awaddr, last_araddr, last_wstrb);
      end
      checks++;
      if (ar_hs !== 4 || r_hs !== 4) begin
         failures++; $display("FAIL basic_reads: ar=%0d r=%0d required 4/4", ar_hs, r_hs);
      end
      checks++;
      if (sample_count !== 16'd1 || res_hs !== 1) begin
         failures++;
         $display("FAIL basic_count: count=%0d handshakes=%0d required 1/1", sample_count, res_hs);
      end
   endtask

   task automatic test_timeout();
      zero_reads = 1000; result_word = 32'h0;
      clear_counts();
      send_sample(16'h0005);
      wait_idle(400);
      checks++;
      if (ar_hs !== 8 || r_hs !== 8) begin
         failures++; $display("FAIL timeout_reads: ar=%0d r=%0d required 8/8", ar_hs, r_hs);
      end
      checks++;
      if (err_timeout !== 1'b1 || err_resp !== 1'b0) begin
         failures++;
         $display("FAIL timeout_flags: err_timeout=%b err_resp=%b required 1/0", err_timeout, err_resp);
      end
      checks++;
      if (tvalid_seen !== 1'b0 || sample_count !== 16'd1) begin
         failures++;
         $display("FAIL timeout_no_result: tvalid_seen=%b count=%0d required 0/1", tvalid_seen, sample_count);
      end
   endtask

   task automatic test_write_order();
      aw_delay = 3; w_delay = 0; zero_reads = 1; result_word = 32'h8000_0042;
      clear_counts();
      send_sample(16'h0010);
      wait_result(300);
      checks++;
      if (m_tdata !== 16'h0042) begin
         failures++; $display("FAIL aw_late_tdata: actual=%h required=0042", m_tdata);
      end
      wait_idle(50);
      checks++;
      if (aw_hs !== 1 || w_hs !== 1 || b_hs !== 1) begin
         failures++; $display("FAIL aw_late_hs: aw=%0d w=%0d b=%0d required 1/1/1", aw_hs, w_hs, b_hs);
      end
      checks++;
      if (w_low_aw_high !== 1'b1 || bready_early !== 1'b0) begin
         failures++;
         $display("FAIL aw_late_order: w_low_aw_high=%b bready_early=%b required 1/0",
                  w_low_aw_high, bready_early);
      end
      checks++;
      if (last_wdata !== 32'h0000_0010) begin
         failures++; $display("FAIL aw_late_wdata: actual=%h required=00000010", last_wdata);
      end

      aw_delay = 0; w_delay = 2; result_word = 32'h8000_0043;
      clear_counts();
      send_sample(16'h0011);
      wait_result(300);
      checks++;
      if (m_tdata !== 16'h0043) begin
         failures++; $display("FAIL w_late_tdata: actual=%h required=0043", m_tdata);
      end
      wait_idle(50);
      checks++;
      if (aw_hs !== 1 || w_hs !== 1 || bready_early !== 1'b0 || sample_count !== 16'd3) begin
         failures++;
         $display("FAIL w_late_hs: aw=%0d w=%0d bready_early=%b count=%0d required 1/1/0/3",
                  aw_hs, w_hs, bready_early, sample_count);
      end
      w_delay = 0;
   endtask

   task automatic test_bresp();
      bresp_cfg = 2'b10; zero_reads = 2; result_word = 32'h8000_ABCD;
      clear_counts();
      send_sample(16'h7FFF);
      wait_result(300);
      checks++;
      if (m_tdata !== 16'hABCD) begin
         failures++; $display("FAIL bresp_tdata: actual=%h required=abcd", m_tdata);
      end
      wait_idle(50);
      checks++;
      if (err_resp !== 1'b1) begin
         failures++; $display("FAIL bresp_err: actual=%b required=1", err_resp);
      end
      checks++;
      if (ar_hs !== 3 || sample_count !== 16'd4 || last_wdata !== 32'h0000_7FFF) begin
         failures++;
         $display("FAIL bresp_flow: ar=%0d count=%0d wdata=%h required 3/4/00007fff",
                  ar_hs, sample_count, last_wdata);
      end
      bresp_cfg = 2'b00;
   endtask

   task automatic test_backpressure();
      bit stable_ok = 1;
      zero_reads = 1; result_word = 32'h8000_5A5A;
      m_tready = 1'b0;
      clear_counts();
      send_sample(16'h1111);
      wait_result(300);
      for (int i = 0; i < 10; i++) begin
         if (m_tvalid !== 1'b1 || m_tdata !== 16'h5A5A || s_tready !== 1'b0) stable_ok = 0;
         @(negedge clk);
      end
      checks++;
      if (stable_ok !== 1'b1 || res_hs !== 0) begin
         failures++;
         $display("FAIL hold_stable: stable=%b handshakes=%0d tdata=%h required 1/0/5a5a",
                  stable_ok, res_hs, m_tdata);
      end
      m_tready = 1'b1;
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || res_hs !== 1 || sample_count !== 16'd5 || s_tready !== 1'b1) begin
         failures++;
         $display("FAIL hold_release: tvalid=%b handshakes=%0d count=%0d tready=%b required 0/1/5/1",
                  m_tvalid, res_hs, sample_count, s_tready);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      zero_reads = 1000; result_word = 32'h0;
      clear_counts();
      send_sample(16'h2222);
      @(negedge clk);
      while (!axi.ARVALID && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (axi.ARVALID !== 1'b1) begin
         failures++; $display("FAIL midrst_arvalid: actual=%b required=1", axi.ARVALID);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, m_tvalid, s_tready} !== 7'b0) begin
         failures++;
         $display("FAIL midrst_valids: actual=%b required=0000000",
                  {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, m_tvalid, s_tready});
      end
      checks++;
      if (sample_count !== 16'd0 || err_timeout !== 1'b0 || err_resp !== 1'b0) begin
         failures++;
         $display("FAIL midrst_state: count=%0d err_timeout=%b err_resp=%b required 0/0/0",
                  sample_count, err_timeout, err_resp);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      zero_reads = 2; result_word = 32'h8000_0777;
      clear_counts();
      wait_idle(20);
      send_sample(16'h3333);
      wait_result(300);
      checks++;
      if (m_tdata !== 16'h0777) begin
         failures++; $display("FAIL midrst_next_tdata: actual=%h required=0777", m_tdata);
      end
      wait_idle(50);
      checks++;
      if (sample_count !== 16'd1 || ar_hs !== 3 || last_wdata !== 32'h0000_3333) begin
         failures++;
         $display("FAIL midrst_next: count=%0d ar=%0d wdata=%h required 1/3/00003333",
                  sample_count, ar_hs, last_wdata);
      end
   endtask

   initial begin
      clear_counts();
      test_reset();
      test_basic();
      test_timeout();
      test_write_order();
      test_bresp();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
